// File: rtl/constraint_sample_gen_pkg.sv
// Shared types and helpers for the constrained sample generator.
// FSM states, LFSR tap constants and the chunk-count helper.
package sampler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

    function automatic int nchunk(input int vec_w, input int lfsr_w);
        return (vec_w + lfsr_w - 1) / lfsr_w;
    endfunction

    // Maximal-length taps for the common widths; other widths get a plain x^w+1 feedback.
    function automatic logic [63:0] lfsr_taps(input int w);
        logic [63:0] t;
        case (w)
            8:       t = 64'h0000_0000_0000_00B8;
            16:      t = 64'h0000_0000_0000_B400;
            32:      t = {32'h0, LFSR_TAPS_32};
            64:      t = 64'hD800_0000_0000_0000;
            default: t = 64'h1 << (w - 1);
        endcase
        return t;
    endfunction

endpackage

// File: rtl/constraint_sample_gen_lfsr.sv
// Right-shifting Galois LFSR with loadable seed; an all-zero seed is replaced by 1
// so the register can never lock up.
module galois_lfsr #(
    parameter int           W    = 32,
    parameter logic [W-1:0] TAPS = W'(32'h80200003),
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED_EFF;
        end else if (load) begin
            state <= (load_val == '0) ? W'(1) : load_val;
        end else if (en) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/constraint_sample_gen.sv
// Builds candidates from LFSR chunks, presents them to an external checker,
// retries on reject and hands accepted samples out over valid/ready.
module constraint_sample_gen
    import sampler_pkg::*;
#(
    parameter int                VEC_W     = 64,
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(1),
    parameter int                MAX_TRIES = 1024,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [VEC_W-1:0]  cand_o,
    input  logic              sat_i,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [VEC_W-1:0]  sample_data,
    output logic              give_up,
    output logic              busy,
    output logic [CNT_W-1:0]  tries_o,
    output logic [CNT_W-1:0]  accept_cnt,
    output logic [CNT_W-1:0]  reject_cnt
);

    localparam int                NCHUNK = nchunk(VEC_W, LFSR_W);
    localparam int                PAD_W  = NCHUNK * LFSR_W;
    localparam int                CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CIDX_W-1:0] LAST   = CIDX_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [31:0]       MAX_T  = 32'(MAX_TRIES);
    localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(lfsr_taps(LFSR_W));

    state_t              state;
    logic [CIDX_W-1:0]   chunk_idx;
    logic [LFSR_W-1:0]   lfsr_state;
    logic [PAD_W-1:0]    cand_next;
    logic                lfsr_en;
    logic                lfsr_load;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign lfsr_en   = (state == GEN);
    assign lfsr_load = seed_load && (state == IDLE);

    galois_lfsr #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (lfsr_en),
        .load     (lfsr_load),
        .load_val (seed_i),
        .state    (lfsr_state)
    );

    // Overlay the current LFSR word onto the chunk slot being generated; the
    // padded top of the last chunk is dropped when the candidate is stored.
    always_comb begin
        cand_next = PAD_W'(cand_o);
        cand_next[int'(chunk_idx) * LFSR_W +: LFSR_W] = lfsr_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            chunk_idx  <= '0;
            cand_o     <= '0;
            give_up    <= 1'b0;
            tries_o    <= '0;
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else begin
            give_up <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= GEN;
                        chunk_idx <= '0;
                        tries_o   <= '0;
                    end
                end
                GEN: begin
                    cand_o <= cand_next[VEC_W-1:0];
                    if (chunk_idx == LAST) begin
                        chunk_idx <= '0;
                        state     <= CHECK;
                    end else begin
                        chunk_idx <= chunk_idx + 1'b1;
                    end
                end
                CHECK: begin
                    tries_o <= sat_inc(tries_o);
                    if (sat_i) begin
                        accept_cnt <= sat_inc(accept_cnt);
                        state      <= HOLD;
                    end else begin
                        reject_cnt <= sat_inc(reject_cnt);
                        if ((32'(tries_o) + 32'd1) < MAX_T) begin
                            state <= GEN;
                        end else begin
                            state   <= IDLE;
                            give_up <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (sample_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state == IDLE) && !seed_load;
    assign sample_valid = (state == HOLD);
    assign sample_data  = cand_o;
    assign busy         = (state != IDLE);

endmodule
